// File: rtl/clock_div_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clock_div_ctrl_pkg
// Purpose  : Shared state encoding and constants for the divider sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package clock_div_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_GATE   = 3'd3,
    ST_LOAD   = 3'd4,
    ST_SETTLE = 3'd5
  } state_e;

  localparam int BYPASS_N  = 0;
  localparam int INIT_HOLD = 2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clock_div_edge_det.sv
`default_nettype none
// ============================================================================
// Module   : clock_div_edge_det
// Purpose  : Samples a divided clock in the source domain, flags falling edges.
// Revision : 1.0 - initial release
// ============================================================================
module clock_div_edge_det (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic div_clk_i,
  output logic fall_o
);

  logic sample_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sample_q <= 1'b0;
    end else begin
      sample_q <= div_clk_i;
    end
  end

  // Strobe is valid at the edge where the new sample (0) follows a 1.
  assign fall_o = sample_q & ~div_clk_i;

endmodule
`default_nettype wire

// File: rtl/clock_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clock_div_ctrl
// Purpose  : Glitch-free runtime ratio changer wrapped around clock_div.
// Revision : 1.0 - initial release
// ============================================================================
module clock_div_ctrl
  import clock_div_ctrl_pkg::*;
#(
  parameter int SIZE          = 3,
  parameter int GATE_CYCLES   = 2,
  parameter int SETTLE_CYCLES = 4,
  parameter int DRAIN_TIMEOUT = 16
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            req_valid_i,
  input  logic [SIZE-1:0] req_N_i,
  output logic            req_ready_o,
  input  logic            div_clk_i,
  output logic [SIZE-1:0] div_N_o,
  output logic            div_reset_n_o,
  output logic            gate_en_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_timeout_o
);

  localparam int CNT_MAX = max3(max3(GATE_CYCLES, SETTLE_CYCLES, DRAIN_TIMEOUT), INIT_HOLD, 1);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] C_CNT_SAT     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_INIT_LAST   = CNT_W'(INIT_HOLD - 1);
  localparam logic [CNT_W-1:0] C_GATE_LAST   = CNT_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_DRAIN_LAST  = CNT_W'(DRAIN_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SIZE-1:0]   div_N_q, div_N_d;
  logic [SIZE-1:0]   pend_q, pend_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              w_fall;
  logic              w_accept;
  logic [SIZE-1:0]   w_req_norm;

  clock_div_edge_det u_edge_det (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .div_clk_i (div_clk_i),
    .fall_o    (w_fall)
  );

  assign w_accept   = (state_q == ST_IDLE) && req_valid_i;
  assign w_req_norm = (req_N_i == SIZE'(1)) ? SIZE'(BYPASS_N) : req_N_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      div_N_q <= '0;
      pend_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_N_q <= div_N_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == C_CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
    div_N_d = div_N_q;
    pend_d  = pend_q;
    done_d  = 1'b0;
    err_d   = err_q;

    case (state_q)
      ST_INIT: begin
        if (cnt_q == C_INIT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      ST_IDLE: begin
        cnt_d = '0;
        if (w_accept) begin
          pend_d = w_req_norm;
          err_d  = 1'b0;
          if (w_req_norm == div_N_q) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // A bypassed divider has no low phase worth waiting for.
        if (div_N_q <= SIZE'(1) || w_fall) begin
          state_d = ST_GATE;
          cnt_d   = '0;
        end else if (cnt_q == C_DRAIN_LAST) begin
          err_d   = 1'b1;
          state_d = ST_GATE;
          cnt_d   = '0;
        end
      end
      ST_GATE: begin
        if (cnt_q == C_GATE_LAST) begin
          state_d = ST_LOAD;
          div_N_d = pend_q;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        state_d = ST_SETTLE;
        cnt_d   = '0;
      end
      ST_SETTLE: begin
        if (cnt_q == C_SETTLE_LAST) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decode straight from state so the async reset reaches them at once.
  assign req_ready_o   = (state_q == ST_IDLE);
  assign busy_o        = (state_q != ST_IDLE);
  assign gate_en_o     = (state_q == ST_IDLE) || (state_q == ST_DRAIN);
  assign div_reset_n_o = (state_q != ST_INIT) && (state_q != ST_LOAD);
  assign div_N_o       = div_N_q;
  assign done_o        = done_q;
  assign err_timeout_o = err_q;

endmodule
`default_nettype wire
